// File: rtl/fme_mv_cost_sel_if.sv
// Candidate/result bus of the FME MV cost selector. The driver side uses
// the master modport; fme_mv_cost_sel uses the slave modport.
interface fme_mv_cost_sel_if #(
   parameter int MV_WIDTH   = 12,
   parameter int SATD_WIDTH = 16,
   parameter int IDX_WIDTH  = 6
);
   logic                         start_i;
   logic signed [MV_WIDTH-1:0]   mvp_x_i;
   logic signed [MV_WIDTH-1:0]   mvp_y_i;
   logic [6:0]                   lambda_i;
   logic                         cand_val_i;
   logic signed [MV_WIDTH-1:0]   cand_mv_x_i;
   logic signed [MV_WIDTH-1:0]   cand_mv_y_i;
   logic [SATD_WIDTH-1:0]        cand_satd_i;
   logic                         cand_last_i;
   logic                         busy_o;
   logic                         done_o;
   logic signed [MV_WIDTH-1:0]   best_mv_x_o;
   logic signed [MV_WIDTH-1:0]   best_mv_y_o;
   logic [SATD_WIDTH+1:0]        best_cost_o;
   logic [IDX_WIDTH-1:0]         best_idx_o;

   modport master (
      output start_i, mvp_x_i, mvp_y_i, lambda_i,
      output cand_val_i, cand_mv_x_i, cand_mv_y_i, cand_satd_i, cand_last_i,
      input  busy_o, done_o, best_mv_x_o, best_mv_y_o, best_cost_o, best_idx_o
   );

   modport slave (
      input  start_i, mvp_x_i, mvp_y_i, lambda_i,
      input  cand_val_i, cand_mv_x_i, cand_mv_y_i, cand_satd_i, cand_last_i,
      output busy_o, done_o, best_mv_x_o, best_mv_y_o, best_cost_o, best_idx_o
   );
endinterface

// File: rtl/fme_mv_cost_sel.sv
// Fractional-MV rate-distortion cost and running-best selection per PU.
// Build option FME_MVD_SAT_EN: saturate MVD magnitudes above 2047 instead of truncating.
module fme_mv_cost_sel #(
   parameter int MV_WIDTH   = 12,
   parameter int SATD_WIDTH = 16,
   parameter int IDX_WIDTH  = 6
) (
   input  logic               clk,
   input  logic               rstn,
   fme_mv_cost_sel_if.slave   bus
);
   localparam int MVD_W  = MV_WIDTH + 1;
   localparam int COST_W = SATD_WIDTH + 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Magnitude of (a - b) evaluated in MV_WIDTH+1 bits, limited to 11 bits.
   function automatic logic [10:0] mvd_mag(input logic [MV_WIDTH-1:0] a,
                                          input logic [MV_WIDTH-1:0] b);
      logic [MVD_W-1:0] d;
      logic [MVD_W-1:0] mag;
      d   = {a[MV_WIDTH-1], a} - {b[MV_WIDTH-1], b};
      mag = d[MVD_W-1] ? (~d + MVD_W'(1)) : d;
`ifdef FME_MVD_SAT_EN
      mvd_mag = (|mag[MVD_W-1:11]) ? 11'd2047 : mag[10:0];
`else
      mvd_mag = mag[10:0];
`endif
   endfunction

   // Exp-Golomb bit count of w = 2*m: 2k+1 with k = MSB index of w, 31 when k = 11.
   function automatic logic [4:0] eg_bits(input logic [10:0] m);
      logic [3:0] k;
      k = 4'd0;
      for (int i = 0; i < 11; i++) begin
         k = m[i] ? 4'(i + 1) : k;
      end
      eg_bits = (k == 4'd11) ? 5'd31 : {k, 1'b1};
   endfunction

   state_t                     state_q, state_d;
   logic                       busy_q, busy_d;
   logic                       done_q, done_d;

   logic signed [MV_WIDTH-1:0] mvp_x_q, mvp_y_q;
   logic [6:0]                 lambda_q;
   logic [IDX_WIDTH-1:0]       cnt_q;
   logic                       last_seen_q;

   logic                       s0_vld_q, s0_last_q;
   logic signed [MV_WIDTH-1:0] s0_mv_x_q, s0_mv_y_q;
   logic [SATD_WIDTH-1:0]      s0_satd_q;
   logic [IDX_WIDTH-1:0]       s0_idx_q;

   logic                       s1_vld_q, s1_last_q;
   logic [10:0]                s1_mag_x_q, s1_mag_y_q;
   logic signed [MV_WIDTH-1:0] s1_mv_x_q, s1_mv_y_q;
   logic [SATD_WIDTH-1:0]      s1_satd_q;
   logic [IDX_WIDTH-1:0]       s1_idx_q;

   logic                       s2_vld_q, s2_last_q;
   logic [COST_W-1:0]          s2_cost_q;
   logic signed [MV_WIDTH-1:0] s2_mv_x_q, s2_mv_y_q;
   logic [IDX_WIDTH-1:0]       s2_idx_q;

   logic                       best_vld_q;
   logic signed [MV_WIDTH-1:0] best_mv_x_q, best_mv_y_q;
   logic [COST_W-1:0]          best_cost_q;
   logic [IDX_WIDTH-1:0]       best_idx_q;

   logic                       acc_s;
   logic                       upd_s;
   logic [5:0]                 bits_sum_s;
   logic [12:0]                rate_s;
   logic [COST_W-1:0]          cost_d;

   // A restart drops any candidate presented in the same cycle.
   assign acc_s = (state_q == ST_RUN) && bus.cand_val_i && !bus.start_i && !last_seen_q;

   assign bits_sum_s = {1'b0, eg_bits(s1_mag_x_q)} + {1'b0, eg_bits(s1_mag_y_q)};
   assign rate_s     = {6'd0, lambda_q} * {7'd0, bits_sum_s};
   assign cost_d     = {2'b00, s1_satd_q} + {{(COST_W-13){1'b0}}, rate_s};

   // Strict less-than keeps the earlier candidate on a tie.
   assign upd_s = s2_vld_q && (!best_vld_q || (s2_cost_q < best_cost_q));

   // Next-state and registered-output decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start_i) state_d = ST_RUN;
            else             state_d = ST_IDLE;
         end
         ST_RUN: begin
            if (bus.start_i)                 state_d = ST_RUN;
            else if (s2_vld_q && s2_last_q)  state_d = ST_DONE;
            else                             state_d = ST_RUN;
         end
         ST_DONE: begin
            if (bus.start_i) state_d = ST_RUN;
            else             state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // PU context and input capture stage.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         mvp_x_q     <= '0;
         mvp_y_q     <= '0;
         lambda_q    <= 7'd0;
         cnt_q       <= '0;
         last_seen_q <= 1'b0;
         s0_vld_q    <= 1'b0;
         s0_last_q   <= 1'b0;
         s0_mv_x_q   <= '0;
         s0_mv_y_q   <= '0;
         s0_satd_q   <= '0;
         s0_idx_q    <= '0;
      end else if (bus.start_i) begin
         mvp_x_q     <= bus.mvp_x_i;
         mvp_y_q     <= bus.mvp_y_i;
         lambda_q    <= bus.lambda_i;
         cnt_q       <= '0;
         last_seen_q <= 1'b0;
         s0_vld_q    <= 1'b0;
      end else begin
         s0_vld_q <= acc_s;
         if (acc_s) begin
            cnt_q       <= cnt_q + IDX_WIDTH'(1);
            last_seen_q <= bus.cand_last_i;
            s0_last_q   <= bus.cand_last_i;
            s0_mv_x_q   <= bus.cand_mv_x_i;
            s0_mv_y_q   <= bus.cand_mv_y_i;
            s0_satd_q   <= bus.cand_satd_i;
            s0_idx_q    <= cnt_q;
         end
      end
   end

   // MVD magnitude stage and cost stage.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         s1_vld_q   <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_mag_x_q <= 11'd0;
         s1_mag_y_q <= 11'd0;
         s1_mv_x_q  <= '0;
         s1_mv_y_q  <= '0;
         s1_satd_q  <= '0;
         s1_idx_q   <= '0;
         s2_vld_q   <= 1'b0;
         s2_last_q  <= 1'b0;
         s2_cost_q  <= '0;
         s2_mv_x_q  <= '0;
         s2_mv_y_q  <= '0;
         s2_idx_q   <= '0;
      end else if (bus.start_i) begin
         s1_vld_q <= 1'b0;
         s2_vld_q <= 1'b0;
      end else begin
         s1_vld_q   <= s0_vld_q;
         s1_last_q  <= s0_last_q;
         s1_mag_x_q <= mvd_mag(s0_mv_x_q, mvp_x_q);
         s1_mag_y_q <= mvd_mag(s0_mv_y_q, mvp_y_q);
         s1_mv_x_q  <= s0_mv_x_q;
         s1_mv_y_q  <= s0_mv_y_q;
         s1_satd_q  <= s0_satd_q;
         s1_idx_q   <= s0_idx_q;
         s2_vld_q   <= s1_vld_q;
         s2_last_q  <= s1_last_q;
         s2_cost_q  <= cost_d;
         s2_mv_x_q  <= s1_mv_x_q;
         s2_mv_y_q  <= s1_mv_y_q;
         s2_idx_q   <= s1_idx_q;
      end
   end

   // Running best; cleared to the idle values by reset and by every start.
   always_ff @(posedge clk) begin
      if (!rstn || bus.start_i) begin
         best_vld_q  <= 1'b0;
         best_mv_x_q <= '0;
         best_mv_y_q <= '0;
         best_cost_q <= '1;
         best_idx_q  <= '0;
      end else if (upd_s) begin
         best_vld_q  <= 1'b1;
         best_mv_x_q <= s2_mv_x_q;
         best_mv_y_q <= s2_mv_y_q;
         best_cost_q <= s2_cost_q;
         best_idx_q  <= s2_idx_q;
      end
   end

   assign bus.busy_o      = busy_q;
   assign bus.done_o      = done_q;
   assign bus.best_mv_x_o = best_mv_x_q;
   assign bus.best_mv_y_o = best_mv_y_q;
   assign bus.best_cost_o = best_cost_q;
   assign bus.best_idx_o  = best_idx_q;
endmodule

// File: tb/tb_fme_mv_cost_sel.sv
// Directed self-checking bench for fme_mv_cost_sel; expected values are hand-computed
// (cost = satd + lambda * (bits_x + bits_y), bits = 2k+1, or 31 when k = 11).
module tb_fme_mv_cost_sel;
   localparam int MV_WIDTH   = 12;
   localparam int SATD_WIDTH = 16;
   localparam int IDX_WIDTH  = 6;
   localparam int COST_ONES  = 262143;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   lat;
   int   seen;

   fme_mv_cost_sel_if #(.MV_WIDTH(MV_WIDTH), .SATD_WIDTH(SATD_WIDTH), .IDX_WIDTH(IDX_WIDTH)) bus ();

   fme_mv_cost_sel #(.MV_WIDTH(MV_WIDTH), .SATD_WIDTH(SATD_WIDTH), .IDX_WIDTH(IDX_WIDTH)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_start(input int px, input int py, input int lam);
      bus.start_i  = 1'b1;
      bus.mvp_x_i  = MV_WIDTH'(px);
      bus.mvp_y_i  = MV_WIDTH'(py);
      bus.lambda_i = 7'(lam);
      tick();
      bus.start_i  = 1'b0;
   endtask

   task automatic do_cand(input int mx, input int my, input int sd, input bit last);
      bus.cand_val_i  = 1'b1;
      bus.cand_mv_x_i = MV_WIDTH'(mx);
      bus.cand_mv_y_i = MV_WIDTH'(my);
      bus.cand_satd_i = SATD_WIDTH'(sd);
      bus.cand_last_i = last;
      tick();
      bus.cand_val_i  = 1'b0;
      bus.cand_last_i = 1'b0;
   endtask

   // Returns ticks until done_o is seen, or 99 if it never comes.
   task automatic wait_done(output int n);
      n = 99;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.done_o === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic check_best(input string tag, input int mx, input int my, input int cost, input int idx);
      check({tag, " mv_x"}, int'(bus.best_mv_x_o), mx);
      check({tag, " mv_y"}, int'(bus.best_mv_y_o), my);
      check({tag, " cost"}, int'(bus.best_cost_o), cost);
      check({tag, " idx"},  int'(bus.best_idx_o),  idx);
   endtask

   initial begin
      bus.start_i     = 1'b0;
      bus.mvp_x_i     = '0;
      bus.mvp_y_i     = '0;
      bus.lambda_i    = 7'd0;
      bus.cand_val_i  = 1'b0;
      bus.cand_mv_x_i = '0;
      bus.cand_mv_y_i = '0;
      bus.cand_satd_i = '0;
      bus.cand_last_i = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst busy", int'(bus.busy_o), 0);
      check("rst done", int'(bus.done_o), 0);
      check_best("rst", 0, 0, COST_ONES, 0);
      rstn = 1'b1;
      tick();

      // Basic PU: costs 140, 138, 156 -> B wins
      do_start(0, 0, 4);
      check("basic busy", int'(bus.busy_o), 1);
      do_cand(4, -1, 100, 1'b0);
      do_cand(0, 0, 130, 1'b0);
      do_cand(1, 1, 132, 1'b1);
      wait_done(lat);
      check("basic latency", lat, 3);
      check_best("basic", 0, 0, 138, 1);
      tick();
      check("basic done pulse", int'(bus.done_o), 0);
      check("basic idle busy", int'(bus.busy_o), 0);
      check("basic hold cost", int'(bus.best_cost_o), 138);

      // Tie at cost 200 keeps the first
      do_start(0, 0, 4);
      do_cand(1, 1, 176, 1'b0);
      do_cand(0, 0, 192, 1'b1);
      wait_done(lat);
      check("tie latency", lat, 3);
      check_best("tie", 1, 1, 200, 0);

      // Bit-count boundary k=10 / k=11
      do_start(0, 0, 1);
      do_cand(512, 0, 0, 1'b1);
      wait_done(lat);
      check("k10 latency", lat, 3);
      check_best("k10", 512, 0, 22, 0);
      do_start(0, 0, 1);
      do_cand(1024, 0, 0, 1'b1);
      wait_done(lat);
      check_best("k11", 1024, 0, 32, 0);

      // Abort one cycle after last; later candidate after last is ignored
      do_start(0, 0, 4);
      do_cand(4, -1, 100, 1'b1);
      do_start(0, 0, 4);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.done_o === 1'b1) seen = 1;
      end
      check("abort no done", seen, 0);
      check("abort busy", int'(bus.busy_o), 1);
      do_cand(0, 0, 50, 1'b1);
      do_cand(0, 0, 0, 1'b0);
      wait_done(lat);
      check("abort new latency", lat, 2);
      check_best("abort new", 0, 0, 58, 0);

      // start_i with simultaneous candidate drops the candidate
      do_start(0, 0, 0);
      bus.cand_val_i  = 1'b1;
      bus.cand_mv_x_i = MV_WIDTH'(7);
      bus.cand_mv_y_i = MV_WIDTH'(0);
      bus.cand_satd_i = SATD_WIDTH'(0);
      bus.cand_last_i = 1'b1;
      do_start(0, 0, 0);
      bus.cand_val_i  = 1'b0;
      bus.cand_last_i = 1'b0;
      do_cand(3, 0, 40, 1'b1);
      wait_done(lat);
      check("prio latency", lat, 3);
      check_best("prio", 3, 0, 40, 0);

      // Index wrap: 66 back-to-back candidates, the 66th (index 65 -> 1) wins
      do_start(0, 0, 0);
      for (int i = 0; i < 66; i++) begin
         do_cand(i, 0, (i == 65) ? 5 : 1000, i == 65);
      end
      wait_done(lat);
      check("wrap latency", lat, 3);
      check_best("wrap", 65, 0, 5, 1);

      // Reset mid-RUN discards the PU
      do_start(0, 0, 4);
      do_cand(0, 0, 10, 1'b0);
      do_cand(0, 0, 10, 1'b1);
      rstn = 1'b0;
      tick();
      check("midrst busy", int'(bus.busy_o), 0);
      check("midrst done", int'(bus.done_o), 0);
      check("midrst cost", int'(bus.best_cost_o), COST_ONES);
      rstn = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.done_o === 1'b1) seen = 1;
      end
      check("midrst no done", seen, 0);

      // MVD 3000: saturates to 2047 (k=11) or truncates to 952 (k=10)
      do_start(-2000, 0, 1);
      do_cand(1000, 0, 0, 1'b1);
      wait_done(lat);
      check("sat latency", lat, 3);
`ifdef FME_MVD_SAT_EN
      check_best("sat", 1000, 0, 32, 0);
`else
      check_best("trunc", 1000, 0, 22, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
